vend_ctrl: RTL

Candy vending machine controller sitting downstream of the keypad encoder. Consumes the 3-bit key code, turns each key press into one event, and keeps the inserted credit. It dispenses candy when credit covers the price and pays change back as a sequence of 500/100 coin pulses. All outputs are registered and drive the dispenser, the coin-return mechanism and the credit display.

---
 rtl/vend_pkg.sv | 15 +
 rtl/vend_ctrl_key_edge.sv | 29 ++
 rtl/vend_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared key codes and FSM state encoding for the candy vending controller.
package vend_pkg;

  localparam logic [2:0] KEY_C100   = 3'b001;
  localparam logic [2:0] KEY_C500   = 3'b010;
  localparam logic [2:0] KEY_CANDY  = 3'b101;
  localparam logic [2:0] KEY_CHANGE = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

endpackage

// File: rtl/vend_ctrl_key_edge.sv
// Two-stage key sampler; flags one event when the code leaves all-zero.
module key_edge #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] key_code,
  output logic         evt,
  output logic [W-1:0] evt_code
);

  logic [W-1:0] key_q;
  logic [W-1:0] key_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q  <= '0;
      key_q2 <= '0;
    end else begin
      key_q  <= key_code;
      key_q2 <= key_q;
    end
  end

  // A nonzero-to-nonzero code change is deliberately not an event.
  assign evt      = (key_q != '0) && (key_q2 == '0);
  assign evt_code = key_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: credit keeping, timed dispense, and 500/100 change payout.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int CW       = 4,
  parameter int DISP_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    key_code,
  output logic [CW-1:0] credit,
  output logic          candy_out,
  output logic          change_100,
  output logic          change_500,
  output logic          coin_reject,
  output logic          no_credit,
  output logic          busy
);

  localparam int DW = (DISP_LEN > 1) ? $clog2(DISP_LEN) : 1;
  localparam logic [CW:0]   MAX_CREDIT = {1'b0, {CW{1'b1}}};
  localparam logic [CW:0]   PRICE_W    = (CW+1)'(PRICE);
  localparam logic [CW-1:0] PRICE_C    = CW'(PRICE);
  localparam logic [CW-1:0] FIVE_C     = CW'(5);
  localparam logic [CW:0]   FIVE_W     = (CW+1)'(5);
  localparam logic [DW-1:0] CNT_LOAD   = DW'(DISP_LEN - 1);

  logic          evt;
  logic [2:0]    evt_code;

  state_t        state, state_d;
  logic [DW-1:0] cnt, cnt_d;
  logic [CW-1:0] credit_d;
  logic          candy_d, c100_d, c500_d, rej_d, nocr_d, busy_d;
  logic [CW:0]   sum_100, sum_500;

  key_edge #(.W(3)) u_key_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_code (key_code),
    .evt      (evt),
    .evt_code (evt_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      credit      <= '0;
      candy_out   <= 1'b0;
      change_100  <= 1'b0;
      change_500  <= 1'b0;
      coin_reject <= 1'b0;
      no_credit   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      credit      <= credit_d;
      candy_out   <= candy_d;
      change_100  <= c100_d;
      change_500  <= c500_d;
      coin_reject <= rej_d;
      no_credit   <= nocr_d;
      busy        <= busy_d;
    end
  end

  // Overflow check runs one bit wider so credit never wraps.
  assign sum_100 = {1'b0, credit} + (CW+1)'(1);
  assign sum_500 = {1'b0, credit} + FIVE_W;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    credit_d = credit;
    candy_d  = 1'b0;
    c100_d   = 1'b0;
    c500_d   = 1'b0;
    rej_d    = 1'b0;
    nocr_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (evt) begin
          case (evt_code)
            KEY_C100: begin
              if (sum_100 > MAX_CREDIT) rej_d = 1'b1;
              else credit_d = sum_100[CW-1:0];
            end
            KEY_C500: begin
              if (sum_500 > MAX_CREDIT) rej_d = 1'b1;
              else credit_d = sum_500[CW-1:0];
            end
            KEY_CANDY: begin
              if ({1'b0, credit} >= PRICE_W) begin
                credit_d = credit - PRICE_C;
                cnt_d    = CNT_LOAD;
                candy_d  = 1'b1;
                state_d  = ST_VEND;
              end else begin
                nocr_d = 1'b1;
              end
            end
            KEY_CHANGE: begin
              if (credit != '0) state_d = ST_CHANGE;
            end
            default: ;
          endcase
        end
      end
      ST_VEND: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt - DW'(1);
          candy_d = 1'b1;
        end
      end
      ST_CHANGE: begin
        if (credit >= FIVE_C) begin
          c500_d   = 1'b1;
          credit_d = credit - FIVE_C;
        end else begin
          c100_d   = 1'b1;
          credit_d = credit - CW'(1);
        end
        if (credit_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // CHANGE keeps busy up through the edge of its final coin pulse.
    busy_d = (state_d != ST_IDLE) || (state == ST_CHANGE);
  end

endmodule
